// File: rtl/rbcp_i2c_bridge.sv
// rbcp_i2c_bridge
//   RBCP local-bus slave sitting behind the SiTCP core. A small register
//   window (offsets 0x00..0x04) holds DEV/REG/WDATA, a CTRL/STAT register
//   and the last I2C read byte. A CTRL write with START=1 snapshots the
//   window into the I2C_* outputs and runs one single-byte transaction
//   on the downstream I2C master over a REQ/BUSY/DONE handshake, guarded
//   by a TIM_1MS based timeout.
//
//   Optional build macro: RBCP_I2C_AUTO_INC_EN
//     defined   - REG is incremented (mod 256) after every ACKed completion
//     undefined - REG changes only on RBCP writes
//
// Ports
//   CLK, RST            system clock, async active-high reset
//   TIM_1MS             1 ms tick
//   LOC_ACT/ADDR/WD/WE/RE  RBCP request side
//   LOC_ACK, LOC_RD     RBCP acknowledge pulse and read data
//   I2C_REQ/RNW/DEV/REG/WDATA  request to the I2C engine (snapshot)
//   I2C_BUSY/DONE/NACK/RDATA   status from the I2C engine
//
// state | meaning
// IDLE  | no transaction; START accepted
// REQ   | I2C_REQ high, waiting for engine to accept (BUSY) or finish
// WAIT  | engine running, waiting for I2C_DONE

module rbcp_i2c_bridge #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int unsigned TIMEOUT_MS = 10
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        TIM_1MS,
   input  logic        LOC_ACT,
   input  logic [31:0] LOC_ADDR,
   input  logic [7:0]  LOC_WD,
   input  logic        LOC_WE,
   input  logic        LOC_RE,
   output logic        LOC_ACK,
   output logic [7:0]  LOC_RD,
   output logic        I2C_REQ,
   output logic        I2C_RNW,
   output logic [6:0]  I2C_DEV,
   output logic [7:0]  I2C_REG,
   output logic [7:0]  I2C_WDATA,
   input  logic        I2C_BUSY,
   input  logic        I2C_DONE,
   input  logic        I2C_NACK,
   input  logic [7:0]  I2C_RDATA
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_MS);

   state_t      state_q, state_d;
   logic [6:0]  dev_q, dev_d;
   logic [7:0]  reg_q, reg_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        nack_q, nack_d;
   logic        tmo_q, tmo_d;
   logic        errb_q, errb_d;
   logic [7:0]  ms_cnt_q, ms_cnt_d;
   logic        start_q, start_d;
   logic        start_rnw_q, start_rnw_d;
   logic        ack_q, ack_d;
   logic [7:0]  rd_q, rd_d;
   logic        i2c_rnw_q, i2c_rnw_d;
   logic [6:0]  i2c_dev_q, i2c_dev_d;
   logic [7:0]  i2c_reg_q, i2c_reg_d;
   logic [7:0]  i2c_wdata_q, i2c_wdata_d;

   logic        hit, wr_en, rd_en, busy;
   logic [7:0]  off, status, rd_mux, ms_inc;
   logic        unused_act;

   assign unused_act = LOC_ACT;

   assign hit    = (LOC_ADDR[31:8] == BASE_ADDR[31:8]);
   assign off    = LOC_ADDR[7:0];
   assign wr_en  = hit & LOC_WE;
   // A simultaneous WE/RE is treated as a write only.
   assign rd_en  = hit & LOC_RE & ~LOC_WE;
   assign busy   = (state_q != ST_IDLE);
   assign status = {4'b0000, errb_q, tmo_q, nack_q, busy};
   assign ms_inc = (ms_cnt_q == 8'hFF) ? ms_cnt_q : ms_cnt_q + 8'd1;

   always_comb begin
      rd_mux = 8'h00;
      case (off)
         8'h00:   rd_mux = {1'b0, dev_q};
         8'h01:   rd_mux = reg_q;
         8'h02:   rd_mux = wdata_q;
         8'h03:   rd_mux = status;
         8'h04:   rd_mux = rdata_q;
         default: rd_mux = 8'h00;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      dev_d       = dev_q;
      reg_d       = reg_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      nack_d      = nack_q;
      tmo_d       = tmo_q;
      errb_d      = errb_q;
      ms_cnt_d    = ms_cnt_q;
      i2c_rnw_d   = i2c_rnw_q;
      i2c_dev_d   = i2c_dev_q;
      i2c_reg_d   = i2c_reg_q;
      i2c_wdata_d = i2c_wdata_q;
      ack_d       = wr_en | rd_en;
      rd_d        = rd_en ? rd_mux : 8'h00;
      // START is acted on in the ACK cycle, so I2C_REQ follows ACK by one cycle.
      start_d     = wr_en && (off == 8'h03) && LOC_WD[0];
      start_rnw_d = LOC_WD[1];

      case (state_q)
         ST_IDLE: begin
            if (start_q) begin
               state_d     = ST_REQ;
               i2c_dev_d   = dev_q;
               i2c_reg_d   = reg_q;
               i2c_wdata_d = wdata_q;
               i2c_rnw_d   = start_rnw_q;
               nack_d      = 1'b0;
               tmo_d       = 1'b0;
               errb_d      = 1'b0;
               ms_cnt_d    = 8'h00;
            end
         end
         ST_REQ, ST_WAIT: begin
            if (start_q)
               errb_d = 1'b1;
            if (I2C_DONE) begin
               state_d = ST_IDLE;
               nack_d  = I2C_NACK;
               if (i2c_rnw_q && !I2C_NACK)
                  rdata_d = I2C_RDATA;
`ifdef RBCP_I2C_AUTO_INC_EN
               if (!I2C_NACK)
                  reg_d = reg_q + 8'd1;
`endif
            end else if (TIM_1MS && (ms_inc == TMO_LIMIT)) begin
               state_d  = ST_IDLE;
               tmo_d    = 1'b1;
               ms_cnt_d = ms_inc;
            end else begin
               if (TIM_1MS)
                  ms_cnt_d = ms_inc;
               if ((state_q == ST_REQ) && I2C_BUSY)
                  state_d = ST_WAIT;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Bus writes come last so they take priority over the auto-increment.
      if (wr_en) begin
         case (off)
            8'h00:   dev_d   = LOC_WD[6:0];
            8'h01:   reg_d   = LOC_WD;
            8'h02:   wdata_d = LOC_WD;
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         dev_q       <= 7'h00;
         reg_q       <= 8'h00;
         wdata_q     <= 8'h00;
         rdata_q     <= 8'h00;
         nack_q      <= 1'b0;
         tmo_q       <= 1'b0;
         errb_q      <= 1'b0;
         ms_cnt_q    <= 8'h00;
         start_q     <= 1'b0;
         start_rnw_q <= 1'b0;
         ack_q       <= 1'b0;
         rd_q        <= 8'h00;
         i2c_rnw_q   <= 1'b0;
         i2c_dev_q   <= 7'h00;
         i2c_reg_q   <= 8'h00;
         i2c_wdata_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         dev_q       <= dev_d;
         reg_q       <= reg_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         nack_q      <= nack_d;
         tmo_q       <= tmo_d;
         errb_q      <= errb_d;
         ms_cnt_q    <= ms_cnt_d;
         start_q     <= start_d;
         start_rnw_q <= start_rnw_d;
         ack_q       <= ack_d;
         rd_q        <= rd_d;
         i2c_rnw_q   <= i2c_rnw_d;
         i2c_dev_q   <= i2c_dev_d;
         i2c_reg_q   <= i2c_reg_d;
         i2c_wdata_q <= i2c_wdata_d;
      end
   end

   assign LOC_ACK   = ack_q;
   assign LOC_RD    = rd_q;
   assign I2C_REQ   = (state_q == ST_REQ);
   assign I2C_RNW   = i2c_rnw_q;
   assign I2C_DEV   = i2c_dev_q;
   assign I2C_REG   = i2c_reg_q;
   assign I2C_WDATA = i2c_wdata_q;

endmodule

// File: doc/rbcp_i2c_bridge.md
Name: rbcp_i2c_bridge

Overview:
RBCP local-bus slave directly downstream of the SiTCP core. It consumes the LOC_ACT/LOC_ADDR/LOC_WE/LOC_RE/LOC_WD bus and returns LOC_ACK/LOC_RD. It exposes a small register window from which single-byte I2C register transactions are launched to the downstream I2C master engine over a req/done handshake, with a millisecond-based timeout.

Parameters:
BASE_ADDR, 32'h0000_0000, window base; the window is decoded on LOC_ADDR[31:8] == BASE_ADDR[31:8]
TIMEOUT_MS, 10, ms ticks allowed from start to I2C_DONE (range 1..255)

Ports:
CLK  in  1  system clock, same as the SiTCP core
RST  in  1  asynchronous, active-high reset
TIM_1MS  in  1  one-cycle 1 ms tick from the SiTCP timer
LOC_ACT  in  1  RBCP active (informational; not required for decode)
LOC_ADDR  in  32  RBCP address
LOC_WD  in  8  RBCP write data
LOC_WE  in  1  RBCP write strobe (1 cycle)
LOC_RE  in  1  RBCP read strobe (1 cycle)
LOC_ACK  out  1  access acknowledge pulse
LOC_RD  out  8  read data, valid with LOC_ACK
I2C_REQ  out  1  transaction request level
I2C_RNW  out  1  1 = read, 0 = write
I2C_DEV  out  7  7-bit device address
I2C_REG  out  8  register address
I2C_WDATA  out  8  write data
I2C_BUSY  in  1  engine has accepted the request and is running
I2C_DONE  in  1  one-cycle completion pulse
I2C_NACK  in  1  NACK status, valid with I2C_DONE
I2C_RDATA  in  8  read data, valid with I2C_DONE

Behaviour:
- Clock and reset: single clock CLK; RST is asynchronous and active-high. Every flop is cleared on RST: all outputs are 0, all registers are 0, and the FSM is in IDLE.
- Register map (offset = LOC_ADDR[7:0]):
  - 0x00 DEV: RW, bits [6:0]; reads return bit 7 = 0.
  - 0x01 REG: RW.
  - 0x02 WDATA: RW.
  - 0x03 CTRL/STAT. Write: bit0 = START, bit1 = RNW. Read: {4'b0, err_busy, timeout, nack, busy}.
  - 0x04 RDATA: RO; writes are acknowledged and ignored.
  - 0x05..0xFF: acknowledged, read 8'h00.
- Outside the window: no LOC_ACK and no state change, so other slaves can answer.
- Bus timing: LOC_ACK is a registered 1-cycle pulse exactly 1 cycle after the LOC_WE/LOC_RE cycle. LOC_RD carries the read data during the ACK cycle and is 0 otherwise.
- If LOC_WE and LOC_RE are asserted in the same cycle, the write wins and a single ACK is produced.
- FSM states: IDLE, REQ, WAIT.
  - IDLE -> REQ on a CTRL write with START=1. On that transition: snapshot DEV/REG/WDATA/RNW into I2C_*; clear nack, timeout and err_busy; reset the ms counter.
  - REQ: I2C_REQ=1. Move to WAIT when I2C_BUSY=1. If I2C_DONE arrives while in REQ, treat it as completion directly.
  - WAIT: I2C_REQ=0; wait for I2C_DONE.
  - Completion: latch nack <= I2C_NACK. If RNW=1 and I2C_NACK=0, RDATA <= I2C_RDATA; otherwise RDATA is unchanged. Return to IDLE.
- Status: busy = (state != IDLE).
- Timeout: the ms counter (8 bits, saturating) increments on TIM_1MS in REQ/WAIT. When it reaches TIMEOUT_MS: set timeout, deassert I2C_REQ, go to IDLE.
- Late DONE: an I2C_DONE arriving in IDLE is ignored.
- START while busy: ignored, err_busy is set sticky, and the in-flight operation is unaffected.
- Register writes while busy: DEV/REG/WDATA writes are accepted and affect only the next start, because the I2C_* outputs hold the snapshot.
- Reset mid-transaction: returns to IDLE immediately with I2C_REQ=0. The downstream engine must tolerate losing its requester.

Optional Feature:
RBCP_I2C_AUTO_INC_EN
- Defined: each completion with nack=0 increments the REG register by 1, wrapping 0xFF -> 0x00. This allows burst access by repeated START writes.
- Undefined: REG changes only on RBCP writes, and no incrementer logic is present.

Test Plan:
- Write DEV=0x50, REG=0x10, WDATA=0xA5, CTRL=0x01 -> I2C_REQ rises 1 cycle after the ACK with I2C_DEV=0x50, REG=0x10, WDATA=0xA5, RNW=0. Engine BUSY, then DONE with NACK=0 -> status reads 0x00.
- Read op CTRL=0x03; engine returns RDATA=0x3C -> reading 0x04 gives 0x3C and status reads 0x00.
- DONE with NACK=1 on a read -> status=0x02 and RDATA keeps its previous value.
- TIMEOUT_MS=3, engine never responds -> after 3 TIM_1MS ticks, status=0x04 and I2C_REQ=0.
- START issued while busy -> status reads 0x09 (busy + err_busy); the original transaction completes with unchanged I2C_* outputs.
- Read/write at BASE+0x100 -> no LOC_ACK. Read at offset 0x20 -> ACK with LOC_RD=0x00.
